fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Fetch stage. Producer side of the IF/ID pipeline register: holds the PC, reads the
//  stall-capable instruction memory, and drives instruction, PC, PC+2 and HALT into IF/ID.
//  Also handles decode-side hold (stall_in), branch/jump redirects, sticky halt and NOP
//  bubble insertion while memory is busy.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  NOP_INSTR  16'h0800  bubble instruction driven whenever no valid instruction is presented
// PORTS
//  clk              in   1   clock; single clock domain
//  rst              in   1   reset, synchronous, active-high
//  stall_in         in   1   hazard unit hold; current instruction not accepted by IF/ID
//  redirect_en      in   1   taken branch/jump resolved downstream
//  redirect_pc      in   16  redirect target
//  imem_addr        out  16  instruction memory address (= PC register)
//  imem_rd          out  1   instruction memory read strobe
//  imem_data        in   16  instruction memory read data, valid when imem_done
//  imem_done        in   1   read complete this cycle
//  imem_stall       in   1   memory busy; request must be held
//  imem_err         in   1   access error (used only with FETCH_ERR_EN)
//  instruction_out  out  16  instruction to IF/ID; NOP_INSTR when valid_out=0
//  pc_no_plus_two   out  16  address of instruction_out
//  pc_next_out      out  16  pc_no_plus_two + 2 (mod 2^16)
//  valid_out        out  1   instruction_out is a real fetched instruction
//  halt_out         out  1   HALT fetched and accepted; sticky
//  err_out          out  1   fetch error flag (tied 0 without FETCH_ERR_EN)
// BEHAVIOUR
//  - Reset: PC=RESET_PC, state FETCH, squash_pend=0; halt_out=0, err_out=0, valid_out=0,
//    instruction_out=NOP_INSTR; imem_rd=1 from the first cycle after reset.
//  - States: FETCH, WAIT, HALTED. imem_rd=1 in FETCH and WAIT, 0 in HALTED; imem_addr=PC.
//  - FETCH: imem_done -> present data same cycle (combinational, 0-cycle latency from
//    imem_done). imem_stall & ~imem_done -> WAIT, address held.
//  - WAIT: hold imem_addr/imem_rd; outputs NOP, valid_out=0; on imem_done present data,
//    return to FETCH.
//  - valid_out = imem_done & ~redirect_en & ~squash_pend & state!=HALTED.
//  - Accept = valid_out & ~stall_in: PC <= PC+2 (16'hFFFE wraps to 16'h0000).
//    valid_out & stall_in: PC held; same address re-read next cycle.
//  - HALT: accepted instruction with [15:11]==5'b00000 -> halt_out=1 that cycle, state
//    HALTED next; halt_out stays 1, outputs NOP, PC frozen until rst.
//  - Redirect (priority over everything except rst): PC <= redirect_pc next cycle; any
//    data returned this cycle is squashed (NOP, valid_out=0, no halt). If redirect_en in
//    WAIT, or in FETCH with imem_stall, set squash_pend: the outstanding response is
//    dropped on imem_done, squash_pend clears, fetch resumes at redirect_pc.
//  - redirect_en while HALTED ignored. Redirect + HALT same cycle: redirect wins.
//  - rst mid-WAIT: outstanding response discarded; restart at RESET_PC.
// CONFIGURATION
//  FETCH_ERR_EN defined: imem_err with imem_done (unsquashed) -> err_out=1 sticky, instruction
//   replaced by NOP, valid_out=0, halt_out=1, state HALTED.
//  FETCH_ERR_EN undefined: imem_err ignored; err_out tied 0.
// TESTING
//  1 Reset, 1-cycle memory, 16'h4000..16'h4006 at 0..6 -> pc_no_plus_two 0,2,4,6; pc_next 2,4,6,8.
//  2 imem_stall 3 cycles on addr 16'h0010 -> 3 NOP/valid_out=0 cycles, imem_addr held 16'h0010.
//  3 stall_in=1 for 2 cycles at PC 16'h0008 -> PC stays 16'h0008, resumes to 16'h000A.
//  4 redirect_en=1, redirect_pc=16'h0100 during WAIT -> late response dropped, next valid at 16'h0100.
//  5 16'h0000 fetched at 16'h0020 -> halt_out=1, imem_rd=0 after, outputs NOP until rst.
//  6 PC 16'hFFFE accepted -> pc_next_out=16'h0000, next fetch addr 16'h0000.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Purpose : IF stage producer; owns the PC, reads the stall-capable instruction
//           memory and drives instruction/PC/PC+2/HALT into IF/ID.
// Option  : `define FETCH_ERR_EN to turn imem_err into a sticky error halt.
// Rev     : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_stall,
  input  logic        imem_err,
  output logic [15:0] instruction_out,
  output logic [15:0] pc_no_plus_two,
  output logic [15:0] pc_next_out,
  output logic        valid_out,
  output logic        halt_out,
  output logic        err_out
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [15:0] C_PC_STEP = 16'd2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic        r_squash_pend;
  logic        w_squash_nxt;

  logic        w_halted;
  logic        w_live;
  logic        w_err_hit;
  logic        w_valid;
  logic        w_accept;
  logic        w_halt_now;

  assign w_halted = (r_state == S_HALTED);

  // A returned word is usable only if nothing squashes it this cycle.
  assign w_live = imem_done & ~redirect_en & ~r_squash_pend & ~w_halted & ~rst;

`ifdef FETCH_ERR_EN
  logic r_err;

  assign w_err_hit = w_live & imem_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_hit) begin
      r_err <= 1'b1;
    end
  end

  assign err_out = ~rst & (r_err | w_err_hit);
`else
  logic w_unused_err;

  assign w_unused_err = imem_err;
  assign w_err_hit    = 1'b0;
  assign err_out      = 1'b0;
`endif

  assign w_valid    = w_live & ~w_err_hit;
  assign w_accept   = w_valid & ~stall_in;
  assign w_halt_now = w_accept & (imem_data[15:11] == 5'b00000);

  assign valid_out       = w_valid;
  assign instruction_out = w_valid ? imem_data : NOP_INSTR;
  assign pc_no_plus_two  = r_pc;
  assign pc_next_out     = r_pc + C_PC_STEP;
  assign halt_out        = ~rst & (w_halted | w_halt_now | w_err_hit);
  assign imem_addr       = r_pc;
  assign imem_rd         = ~rst & ~w_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_squash_pend <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_squash_pend <= w_squash_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_squash_nxt = r_squash_pend;

    if (!w_halted) begin
      if (redirect_en) begin
        w_pc_nxt = redirect_pc;
        // An in-flight request whose answer has not yet come back must be dropped.
        w_squash_nxt = ~imem_done & ((r_state == S_WAIT) | imem_stall | r_squash_pend);
        w_state_nxt  = w_squash_nxt ? S_WAIT : S_FETCH;
      end else if (r_squash_pend) begin
        if (imem_done) begin
          w_squash_nxt = 1'b0;
          w_state_nxt  = S_FETCH;
        end else begin
          w_state_nxt  = S_WAIT;
        end
      end else if (imem_done) begin
        w_state_nxt = S_FETCH;
        if (w_err_hit) begin
          w_state_nxt = S_HALTED;
        end else if (w_accept) begin
          w_pc_nxt = r_pc + C_PC_STEP;
          if (w_halt_now) begin
            w_state_nxt = S_HALTED;
          end
        end
      end else if (imem_stall || (r_state == S_WAIT)) begin
        w_state_nxt = S_WAIT;
      end else begin
        w_state_nxt = S_FETCH;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Directed scoreboard bench for fetch_unit (default build).
// Rev     : 1.0
// ============================================================================
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        err_drv = 1'b0;
  int          busy = 0;

  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        imem_stall;
  logic [15:0] instruction_out;
  logic [15:0] pc_no_plus_two;
  logic [15:0] pc_next_out;
  logic        valid_out;
  logic        halt_out;
  logic        err_out;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] nxt;
    logic        halt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Memory: word at A is 16'h4000+A, except a HALT (16'h0000) at 16'h0020.
  assign imem_done  = imem_rd & (busy == 0);
  assign imem_stall = imem_rd & (busy != 0);
  assign imem_data  = (imem_addr == 16'h0020) ? 16'h0000 : 16'h4000 + imem_addr;

  fetch_unit #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .imem_data      (imem_data),
    .imem_done      (imem_done),
    .imem_stall     (imem_stall),
    .imem_err       (err_drv),
    .instruction_out(instruction_out),
    .pc_no_plus_two (pc_no_plus_two),
    .pc_next_out    (pc_next_out),
    .valid_out      (valid_out),
    .halt_out       (halt_out),
    .err_out        (err_out)
  );

  task automatic push(input logic [15:0] pc, input logic [15:0] instr,
                      input logic [15:0] nxt, input logic halt);
    exp_t x;
    x.pc = pc; x.instr = instr; x.nxt = nxt; x.halt = halt;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (busy > 0) busy--;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (valid_out && !stall_in) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_accept pc=%h instr=%h want=none", pc_no_plus_two, instruction_out);
        end else begin
          e = q.pop_front();
          if ({instruction_out, pc_no_plus_two, pc_next_out, halt_out} !==
              {e.instr, e.pc, e.nxt, e.halt}) begin
            errors++;
            $display("FAIL accept got instr=%h pc=%h nxt=%h halt=%b want instr=%h pc=%h nxt=%h halt=%b",
                     instruction_out, pc_no_plus_two, pc_next_out, halt_out,
                     e.instr, e.pc, e.nxt, e.halt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    probe();
    chk("rst_valid", {15'd0, valid_out}, 16'd0);
    chk("rst_instr", instruction_out, NOP);
    chk("rst_halt", {15'd0, halt_out}, 16'd0);
    chk("rst_err", {15'd0, err_out}, 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    step();

    // Sequential fetch from 0 with a 1-cycle memory
    push(16'h0000, 16'h4000, 16'h0002, 1'b0);
    push(16'h0002, 16'h4002, 16'h0004, 1'b0);
    push(16'h0004, 16'h4004, 16'h0006, 1'b0);
    push(16'h0006, 16'h4006, 16'h0008, 1'b0);
    rst = 1'b0;
    probe();
    chk("rd_after_rst", {15'd0, imem_rd}, 16'd1);
    repeat (4) step();

    // Decode hold at PC 8 for two cycles
    stall_in = 1'b1;
    probe();
    chk("hold_valid", {15'd0, valid_out}, 16'd1);
    chk("hold_pc0", pc_no_plus_two, 16'h0008);
    step();
    probe();
    chk("hold_pc1", pc_no_plus_two, 16'h0008);
    step();
    push(16'h0008, 16'h4008, 16'h000A, 1'b0);
    push(16'h000A, 16'h400A, 16'h000C, 1'b0);
    push(16'h000C, 16'h400C, 16'h000E, 1'b0);
    push(16'h000E, 16'h400E, 16'h0010, 1'b0);
    stall_in = 1'b0;
    step();
    probe();
    chk("resume_pc", pc_no_plus_two, 16'h000A);
    repeat (3) step();

    // Memory busy for 3 cycles at 0x0010
    push(16'h0010, 16'h4010, 16'h0012, 1'b0);
    busy = 3;
    for (int i = 0; i < 3; i++) begin
      probe();
      chk("mstall_valid", {15'd0, valid_out}, 16'd0);
      chk("mstall_instr", instruction_out, NOP);
      chk("mstall_addr", imem_addr, 16'h0010);
      chk("mstall_rd", {15'd0, imem_rd}, 16'd1);
      step();
    end
    step();

    // Redirect while waiting on memory at 0x0012
    push(16'h0100, 16'h4100, 16'h0102, 1'b0);
    busy = 2;
    probe();
    chk("w_valid0", {15'd0, valid_out}, 16'd0);
    step();
    redirect_en = 1'b1;
    redirect_pc = 16'h0100;
    probe();
    chk("w_valid1", {15'd0, valid_out}, 16'd0);
    step();
    redirect_en = 1'b0;
    probe();
    chk("late_drop_valid", {15'd0, valid_out}, 16'd0);
    chk("late_drop_addr", imem_addr, 16'h0100);
    step();
    probe();
    chk("redir_pc", pc_no_plus_two, 16'h0100);
    step();

    // Redirect to 0xFFFE and wrap
    push(16'hFFFE, 16'h3FFE, 16'h0000, 1'b0);
    push(16'h0000, 16'h4000, 16'h0002, 1'b0);
    redirect_en = 1'b1;
    redirect_pc = 16'hFFFE;
    probe();
    chk("redir_squash", {15'd0, valid_out}, 16'd0);
    step();
    redirect_en = 1'b0;
    probe();
    chk("wrap_next", pc_next_out, 16'h0000);
    step();
    probe();
    chk("wrap_addr", imem_addr, 16'h0000);
    step();

    // HALT at 0x0020
    push(16'h0020, 16'h0000, 16'h0022, 1'b1);
    redirect_en = 1'b1;
    redirect_pc = 16'h0020;
    step();
    redirect_en = 1'b0;
    probe();
    chk("halt_now", {15'd0, halt_out}, 16'd1);
    step();
    probe();
    chk("halted_rd", {15'd0, imem_rd}, 16'd0);
    chk("halted_valid", {15'd0, valid_out}, 16'd0);
    chk("halted_instr", instruction_out, NOP);
    chk("halted_flag", {15'd0, halt_out}, 16'd1);
    redirect_en = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect_en = 1'b0;
    probe();
    chk("halted_redir_halt", {15'd0, halt_out}, 16'd1);
    chk("halted_redir_rd", {15'd0, imem_rd}, 16'd0);
    chk("halted_redir_valid", {15'd0, valid_out}, 16'd0);

    // Reset leaves HALTED and restarts at RESET_PC
    rst = 1'b1;
    step();
    push(16'h0000, 16'h4000, 16'h0002, 1'b0);
    rst = 1'b0;
    probe();
    chk("post_rst_addr", imem_addr, 16'h0000);
    chk("post_rst_halt", {15'd0, halt_out}, 16'd0);
    chk("post_rst_valid", {15'd0, valid_out}, 16'd1);
    rst = 1'b1;
    step();
    step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
